// File: rtl/regfile_mw.sv
// regfile_mw: two-write, nrd-read register file with reset-triggered clear engine; define REGFILE_MW_BYPASS_EN for write-to-read bypass
module regfile_mw #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo = 0,
    parameter int hi = 31,
    parameter int nrd = 4,
    parameter logic [data_width-1:0] init_val = '0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WE_0,
    input  logic [addr_width-1:0]       ADDR_IN_0,
    input  logic [data_width-1:0]       D_IN_0,
    input  logic                        WE_1,
    input  logic [addr_width-1:0]       ADDR_IN_1,
    input  logic [data_width-1:0]       D_IN_1,
    input  logic [nrd*addr_width-1:0]   RD_ADDR,
    output logic [nrd*data_width-1:0]   RD_DATA,
    output logic                        RDY,
    output logic                        ERR
);
    localparam int N = hi - lo + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [addr_width:0] LO_W = lo[addr_width:0];
    localparam logic [addr_width:0] HI_W = hi[addr_width:0];
    localparam logic [addr_width:0] SPAN = HI_W - LO_W;
    localparam logic [addr_width:0] ONE = 1;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                state_q, state_d;
    logic [addr_width:0]   ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic [data_width-1:0] arr_q [N];
    logic [data_width-1:0] arr_d [N];
    logic [addr_width:0]   pofs;

    // An address below lo wraps to >= 2^addr_width, which always exceeds SPAN
    function automatic logic [addr_width:0] off_of(input logic [addr_width-1:0] a);
        return {1'b0, a} - LO_W;
    endfunction

    function automatic logic in_rng(input logic [addr_width-1:0] a);
        return off_of(a) <= SPAN;
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [addr_width-1:0] a);
        logic [addr_width:0] o;
        o = off_of(a);
        return o[IW-1:0];
    endfunction

    assign pofs = ptr_q - LO_W;
    assign RDY  = (state_q == RUN);
    assign ERR  = err_q;

    // Clear engine walks lo..hi; once running, apply both write ports with port 1 last so it wins
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        arr_d   = arr_q;
        if (state_q == CLEAR) begin
            arr_d[pofs[IW-1:0]] = init_val;
            ptr_d   = ptr_q + ONE;
            state_d = (ptr_q == HI_W) ? RUN : CLEAR;
        end else begin
            if (WE_0) begin
                if (in_rng(ADDR_IN_0)) arr_d[idx_of(ADDR_IN_0)] = D_IN_0;
                else err_d = 1'b1;
            end
            if (WE_1) begin
                if (in_rng(ADDR_IN_1)) arr_d[idx_of(ADDR_IN_1)] = D_IN_1;
                else err_d = 1'b1;
            end
        end
    end

    // Control state with synchronous active-low reset restarting the clear
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= CLEAR;
            ptr_q   <= LO_W;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: reads are gated until the clear engine has filled it
    always_ff @(posedge CLK) begin
        arr_q <= arr_d;
    end

    for (genvar k = 0; k < nrd; k++) begin : g_rd
        logic [addr_width-1:0] ra;
        logic [data_width-1:0] rv;
        assign ra = RD_ADDR[k*addr_width +: addr_width];
        // Combinational read; zero while clearing or out of range, optional same-cycle forwarding
        always_comb begin
            rv = (RDY && in_rng(ra)) ? arr_q[idx_of(ra)] : '0;
`ifdef REGFILE_MW_BYPASS_EN
            if (RDY && in_rng(ra) && WE_0 && ADDR_IN_0 == ra) rv = D_IN_0;
            if (RDY && in_rng(ra) && WE_1 && ADDR_IN_1 == ra) rv = D_IN_1;
`else
`endif
        end
        assign RD_DATA[k*data_width +: data_width] = rv;
    end
endmodule

// File: tb/tb_regfile_mw.sv
// tb_regfile_mw: scoreboard bench for regfile_mw (aw=4, dw=8, 0..11, 3 read ports, init A5)
module tb_regfile_mw;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE_0 = 1'b0, WE_1 = 1'b0;
    logic [3:0]  ADDR_IN_0 = '0, ADDR_IN_1 = '0;
    logic [7:0]  D_IN_0 = '0, D_IN_1 = '0;
    logic [11:0] RD_ADDR = '0;
    logic [23:0] RD_DATA;
    logic        RDY, ERR;

    int checks = 0;
    int failures = 0;
    logic [7:0] mem [12];

    typedef struct { string tag; int sel; logic [7:0] exp; } exp_t;
    exp_t sb[$];

    regfile_mw #(.addr_width(4), .data_width(8), .lo(0), .hi(11), .nrd(3), .init_val(8'hA5)) dut (
        .CLK(CLK), .RST(RST),
        .WE_0(WE_0), .ADDR_IN_0(ADDR_IN_0), .D_IN_0(D_IN_0),
        .WE_1(WE_1), .ADDR_IN_1(ADDR_IN_1), .D_IN_1(D_IN_1),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RDY(RDY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        if (sel < 3) return RD_DATA[sel*8 +: 8];
        if (sel == 3) return {7'b0, RDY};
        return {7'b0, ERR};
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.tag, obs(x.sel), x.exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_rd(input string tag, input logic [3:0] a0, a1, a2, input logic [7:0] e0, e1, e2);
        RD_ADDR = {a2, a1, a0};
        push({tag, "_l0"}, 0, e0);
        push({tag, "_l1"}, 1, e1);
        push({tag, "_l2"}, 2, e2);
        drain();
    endtask

    task automatic wr2(input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        WE_0 = w0; ADDR_IN_0 = a0; D_IN_0 = d0;
        WE_1 = w1; ADDR_IN_1 = a1; D_IN_1 = d1;
        step();
        WE_0 = 1'b0; WE_1 = 1'b0;
        if (w0 && a0 <= 4'd11) mem[a0] = d0;
        if (w1 && a1 <= 4'd11) mem[a1] = d1;
    endtask

    task automatic dump(input string tag);
        for (int i = 0; i < 12; i += 3)
            exp_rd(tag, 4'(i), 4'(i + 1), 4'(i + 2), mem[i], mem[i + 1], mem[i + 2]);
    endtask

    initial begin
        for (int i = 0; i < 12; i++) mem[i] = 8'hA5;
        repeat (3) step();
        push("rst_rdy", 3, 8'h00);
        push("rst_err", 4, 8'h00);
        exp_rd("rst_rd", 4'd0, 4'd5, 4'd11, 8'h00, 8'h00, 8'h00);
        RST = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            push($sformatf("clr_rdy_e%0d", i), 3, 8'h00);
            push($sformatf("clr_rd_e%0d", i), 0, 8'h00);
            drain();
        end
        step();
        push("clr_done_rdy", 3, 8'h01);
        exp_rd("clr_done", 4'd0, 4'd5, 4'd11, 8'hA5, 8'hA5, 8'hA5);

        wr2(1'b1, 4'd3, 8'h11, 1'b1, 4'd7, 8'h22);
        push("dual_err", 4, 8'h00);
        exp_rd("dual", 4'd3, 4'd7, 4'd0, 8'h11, 8'h22, 8'hA5);

        wr2(1'b1, 4'd4, 8'h33, 1'b1, 4'd4, 8'h44);
        exp_rd("coll", 4'd4, 4'd3, 4'd7, 8'h44, 8'h11, 8'h22);

        WE_1 = 1'b1; ADDR_IN_1 = 4'd2; D_IN_1 = 8'h66;
`ifdef REGFILE_MW_BYPASS_EN
        exp_rd("byp_same", 4'd2, 4'd3, 4'd12, 8'h66, 8'h11, 8'h00);
`else
        exp_rd("byp_same", 4'd2, 4'd3, 4'd12, 8'hA5, 8'h11, 8'h00);
`endif
        step();
        WE_1 = 1'b0;
        mem[2] = 8'h66;
        exp_rd("byp_next", 4'd2, 4'd3, 4'd12, 8'h66, 8'h11, 8'h00);

        WE_0 = 1'b1; ADDR_IN_0 = 4'd8; D_IN_0 = 8'h77;
        WE_1 = 1'b1; ADDR_IN_1 = 4'd8; D_IN_1 = 8'h88;
`ifdef REGFILE_MW_BYPASS_EN
        exp_rd("byp_prio", 4'd0, 4'd8, 4'd8, 8'hA5, 8'h88, 8'h88);
`else
        exp_rd("byp_prio", 4'd0, 4'd8, 4'd8, 8'hA5, 8'hA5, 8'hA5);
`endif
        step();
        WE_0 = 1'b0; WE_1 = 1'b0;
        mem[8] = 8'h88;
        exp_rd("prio_next", 4'd8, 4'd4, 4'd2, 8'h88, 8'h44, 8'h66);

        WE_0 = 1'b1; ADDR_IN_0 = 4'd13; D_IN_0 = 8'h55;
        push("err_pre", 4, 8'h00);
        drain();
        step();
        WE_0 = 1'b0;
        push("err_set", 4, 8'h01);
        exp_rd("err_rd", 4'd13, 4'd15, 4'd12, 8'h00, 8'h00, 8'h00);
        dump("err_arr");
        for (int i = 0; i < 10; i++) begin
            wr2(1'b1, 4'(i), 8'(8'h60 + i), 1'b0, 4'd0, 8'h00);
            push($sformatf("err_sticky_%0d", i), 4, 8'h01);
            drain();
        end
        dump("legal_arr");

        RST = 1'b0;
        step();
        push("rst2_err", 4, 8'h00);
        push("rst2_rdy", 3, 8'h00);
        exp_rd("rst2_rd", 4'd0, 4'd1, 4'd2, 8'h00, 8'h00, 8'h00);
        RST = 1'b1;
        WE_0 = 1'b1; ADDR_IN_0 = 4'd1; D_IN_0 = 8'h99;
        WE_1 = 1'b1; ADDR_IN_1 = 4'd14; D_IN_1 = 8'h77;
        for (int i = 1; i <= 5; i++) begin
            step();
            push($sformatf("mid_rdy_e%0d", i), 3, 8'h00);
            drain();
        end
        RST = 1'b0;
        step();
        RST = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            push($sformatf("re_rdy_e%0d", i), 3, 8'h00);
            push($sformatf("re_err_e%0d", i), 4, 8'h00);
            drain();
        end
        step();
        WE_0 = 1'b0; WE_1 = 1'b0;
        push("re_done_rdy", 3, 8'h01);
        push("re_done_err", 4, 8'h00);
        exp_rd("re_done", 4'd1, 4'd14, 4'd0, 8'hA5, 8'h00, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mw.md
# regfile_mw

Parametrised multi-port register file with two write ports, N read ports, deterministic post-reset clearing and write-range error reporting. It succeeds the fixed five-read/one-write register file for blocks that need dual-issue writeback, such as CPU integer/FP register files and tag/state arrays. A reset-triggered clear engine initialises every entry to a known value, and the block exposes a ready flag so that consumers can hold off until clearing has finished.

## Interface
- addr_width, 5, address width of every port
- data_width, 32, entry width
- lo, 0, lowest valid index
- hi, 31, highest valid index; depth N = hi-lo+1
- nrd, 4, number of read ports (1..8)
- init_val, 0, value written to every entry by the clear engine

Ports:
- CLK  in  1  clock; all state changes on its rising edge
- RST  in  1  reset; synchronous, active-low
- WE_0  in  1  write enable, port 0
- ADDR_IN_0  in  addr_width  write address, port 0
- D_IN_0  in  data_width  write data, port 0
- WE_1  in  1  write enable, port 1
- ADDR_IN_1  in  addr_width  write address, port 1
- D_IN_1  in  data_width  write data, port 1
- RD_ADDR  in  nrd*addr_width  packed read addresses; port k at bits [k*addr_width +: addr_width]
- RD_DATA  out  nrd*data_width  packed read data, same packing
- RDY  out  1  clearing complete; writes accepted
- ERR  out  1  sticky flag for an out-of-range write

## Operation
- States: CLEAR and RUN. RST=0 at an edge forces CLEAR, sets the clear pointer to lo, and sets RDY=0 and ERR=0.
- CLEAR:
  - Each edge with RST=1 writes init_val to arr[ptr] and increments ptr.
  - The edge that writes hi moves the block to RUN and sets RDY=1.
  - User writes are dropped silently and do not set ERR.
- RUN:
  - An edge with WE_p=1 and lo<=ADDR_IN_p<=hi writes D_IN_p.
  - If both ports write the same address, port 1 wins.
  - A write with WE_p=1 and an out-of-range address is dropped and sets ERR. ERR stays set until reset.
- Read is combinational: RD_DATA[k] = arr[RD_ADDR[k]].
  - An out-of-range read returns 0.
  - While RDY=0 every RD_DATA lane is 0.
- Reset asserted during CLEAR or RUN restarts clearing from lo. Contents are not preserved.
- Addresses compare unsigned. ptr is addr_width+1 bits wide so that hi = 2^addr_width-1 does not wrap early.

## Timing
- Reset values: RDY=0, ERR=0, RD_DATA=0 (all lanes).
- Clear latency: RDY rises N edges after the first edge that samples RST=1. It is observable after edge N.
- Write-to-read latency is 1 cycle: data written at edge t is visible on RD_DATA after edge t. It is not visible in the same cycle, unless bypass is enabled (see Configuration).
- ERR rises after the edge that samples the offending write.
- There is no back-pressure. Every in-range write presented while RDY=1 is committed at that edge.

## Configuration
- REGFILE_MW_BYPASS_EN defined:
  - While RDY=1, a read port whose address matches an active, in-range write this cycle returns that write's D_IN combinationally.
  - If both write ports match, port 1's data is returned.
  - The array update itself is unchanged.
- REGFILE_MW_BYPASS_EN undefined: reads return the pre-edge array contents only. There is no combinational path from D_IN to RD_DATA.

## Test plan
Parameters: addr_width=4, data_width=8, lo=0, hi=11, nrd=3, init_val=8'hA5.
- Reset and clear: hold RST=0 for 3 edges, then release.
  - RDY=0 and all RD_DATA=0 for edges 1–11; RDY=1 after edge 12.
  - Reading addresses 0, 5 and 11 then returns A5.
- Dual write, distinct addresses: WE_0 addr 3 data 11, WE_1 addr 7 data 22 in one cycle.
  - Next cycle, reads of 3/7/0 return 11/22/A5. ERR=0.
- Write collision: both ports write addr 4, port 0 with 33 and port 1 with 44.
  - Read of 4 returns 44.
- Range error: WE_0 to addr 13 with data 55.
  - ERR=1 from the next cycle and stays 1 across 10 further legal writes.
  - Read of 13 returns 0. No in-range entry changes.
- Reset mid-clear: release RST, then reassert it for 1 edge after 5 edges.
  - RDY stays 0 and rises exactly 12 edges after the second release.
  - Writes presented during clearing are dropped and ERR stays 0.
- Bypass (macro defined): WE_1 addr 2 data 66 while RD_ADDR lane 0 = 2.
  - Same cycle, lane 0 = 66.
  - Without the macro, lane 0 shows the old value (A5) that cycle and 66 the next.
